// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: owns the PS/2 clock, sends 11-bit frames (start, 8 data LSB first,
// odd parity, stop) through open-drain enables, backs off on host inhibit and retries the byte.
module ps2_device_tx #(
   parameter int QTR      = 1000,
   parameter int IDLE_CYC = 2500
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_abort,
   output logic       host_rts,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int SLOT = 4 * QTR;
   localparam int PW   = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int IW   = $clog2(IDLE_CYC + 1);

   localparam logic [PW-1:0] P_LAST   = PW'(SLOT - 1);
   localparam logic [PW-1:0] P_LO     = PW'(QTR);
   localparam logic [PW-1:0] P_HI     = PW'(3 * QTR);
   localparam logic [IW-1:0] IDLE_END = IW'(IDLE_CYC);
   localparam logic [2:0]    HOLD     = 3'd4;
   localparam logic [3:0]    BIT_LAST = 4'd10;
   localparam logic [3:0]    BIT_END  = 4'd11;
   localparam logic [3:0]    BIT_CHK  = 4'd9;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_IDLE, S_SEND} state_t;

   state_t        state;
   logic          clk_sync_p0, clk_sync_p1;
   logic          dat_sync_p0, dat_sync_p1;
   logic [7:0]    tx_byte;
   logic          tx_par;
   logic [IW-1:0] idle_cnt;
   logic [PW-1:0] phase;
   logic [3:0]    bit_idx;
   logic [2:0]    rel_cnt;
   logic          bus_idle;
   logic          clk_low_win;
   logic          inhibit;

   // Frame bit by index: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic par, input logic [3:0] idx);
      logic [15:0] fr;
      fr = {5'b11111, 1'b1, par, b, 1'b0};
      return fr[idx];
   endfunction

   assign bus_idle    = clk_sync_p1 & dat_sync_p1;
   assign clk_low_win = (phase >= P_LO) && (phase < P_HI);

   // rel_cnt hides our own released clock until the synchronized pad has had time to rise.
   assign inhibit = (state == S_SEND) && (bit_idx <= BIT_CHK) && !ps2_clk_oe &&
                    (rel_cnt == HOLD) && !clk_sync_p1;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         clk_sync_p0 <= 1'b0;
         clk_sync_p1 <= 1'b0;
         dat_sync_p0 <= 1'b0;
         dat_sync_p1 <= 1'b0;
         tx_byte     <= '0;
         tx_par      <= 1'b0;
         idle_cnt    <= '0;
         phase       <= '0;
         bit_idx     <= '0;
         rel_cnt     <= '0;
         tx_ready    <= 1'b1;
         tx_done     <= 1'b0;
         tx_abort    <= 1'b0;
         host_rts    <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_dat_oe  <= 1'b0;
      end else begin
         clk_sync_p0 <= ps2_clk_in;
         clk_sync_p1 <= clk_sync_p0;
         dat_sync_p0 <= ps2_dat_in;
         dat_sync_p1 <= dat_sync_p0;
         tx_done     <= 1'b0;
         tx_abort    <= 1'b0;
         host_rts    <= 1'b0;

         if (ps2_clk_oe)
            rel_cnt <= '0;
         else if (rel_cnt != HOLD)
            rel_cnt <= rel_cnt + 3'd1;

         case (state)
            S_IDLE: begin
               tx_ready   <= 1'b1;
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               if (tx_valid && tx_ready) begin
                  tx_byte  <= tx_data;
                  tx_par   <= ~^tx_data;
                  tx_ready <= 1'b0;
                  idle_cnt <= '0;
                  state    <= S_WAIT_IDLE;
               end
            end

            S_WAIT_IDLE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               host_rts   <= clk_sync_p1 & ~dat_sync_p1;
               if (idle_cnt == IDLE_END) begin
                  state   <= S_SEND;
                  phase   <= '0;
                  bit_idx <= '0;
               end else if (bus_idle) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end else begin
                  idle_cnt <= '0;
               end
            end

            S_SEND: begin
               if (inhibit) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  tx_abort   <= 1'b1;
                  idle_cnt   <= '0;
                  state      <= S_WAIT_IDLE;
               end else begin
                  ps2_clk_oe <= clk_low_win;
                  if (phase == '0) begin
                     if (bit_idx == BIT_END) begin
                        ps2_dat_oe <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        tx_done    <= 1'b1;
                        state      <= S_IDLE;
                     end else begin
                        ps2_dat_oe <= ~frame_bit(tx_byte, tx_par, bit_idx);
                     end
                  end
                  if (phase == P_LAST) begin
                     phase <= '0;
                     if (bit_idx <= BIT_LAST)
                        bit_idx <= bit_idx + 4'd1;
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: open-drain pad model, host receiver on device clock pulses,
// scoreboard of expected frames/aborts/snapshots checked by a separate monitor.
module tb_ps2_device_tx;

   localparam int QTR       = 4;
   localparam int IDLE_CYC  = 16;
   localparam int FRAME_CYC = 44 * QTR;
   localparam int ACC_LAT   = IDLE_CYC + 3;

   localparam int ID_RST       = 1;
   localparam int ID_IDLE      = 2;
   localparam int ID_DONE_CYC  = 3;
   localparam int ID_READY     = 4;
   localparam int ID_INH_HOLD  = 5;
   localparam int ID_RTS       = 6;
   localparam int ID_RTS_PRE   = 7;
   localparam int ID_RTS_START = 8;
   localparam int ID_PRE_RST   = 9;
   localparam int ID_RST_MID   = 10;
   localparam int ID_RST_REL   = 11;
   localparam int ID_TMO_DONE  = 12;
   localparam int ID_TMO_ACC   = 13;
   localparam int ID_TMO_CLK   = 14;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n  = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_abort, host_rts;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       host_clk_low = 1'b0;
   logic       host_dat_low = 1'b0;
   logic       pad_clk, pad_dat;

   assign pad_clk = ~(ps2_clk_oe | host_clk_low);
   assign pad_dat = ~(ps2_dat_oe | host_dat_low);

   ps2_device_tx #(.QTR(QTR), .IDLE_CYC(IDLE_CYC)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_abort   (tx_abort),
      .host_rts   (host_rts),
      .ps2_clk_in (pad_clk),
      .ps2_dat_in (pad_dat),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   logic [10:0] exp_frame_q[$];
   bit          exp_acc_q[$];
   int          abort_q[$];
   logic [5:0]  snap_exp_q[$];
   logic [5:0]  snap_mask_q[$];
   int          snap_id_q[$];

   int  n_cmp = 0;
   int  n_fail = 0;
   bit  end_req = 1'b0;
   bit  end_ack = 1'b0;

   function automatic string snap_name(input int id);
      case (id)
         ID_RST:       return "reset_state";
         ID_IDLE:      return "idle_state";
         ID_DONE_CYC:  return "done_cycle";
         ID_READY:     return "ready_after_done";
         ID_INH_HOLD:  return "released_during_inhibit";
         ID_RTS:       return "host_rts";
         ID_RTS_PRE:   return "rts_release_pre_start";
         ID_RTS_START: return "rts_release_start_bit";
         ID_PRE_RST:   return "mid_frame_bit6";
         ID_RST_MID:   return "reset_mid_frame";
         ID_RST_REL:   return "after_reset_release";
         ID_TMO_DONE:  return "timeout_tx_done";
         ID_TMO_ACC:   return "timeout_accept";
         ID_TMO_CLK:   return "timeout_clock_pulse";
         default:      return "snapshot";
      endcase
   endfunction

   // Monitor: host receiver plus scoreboard checks.
   logic [10:0] rx_frame = '0;
   int          rx_cnt = 0;
   int          start_cyc = -1;
   int          acc_cyc = 0;
   logic        prev_clk_oe = 1'b0;
   logic        prev_dat_oe = 1'b0;
   logic [5:0]  act, se, sm;
   int          sid;
   logic [10:0] ef;
   bit          ea;

   always @(negedge CLOCK_50) begin
      act = {tx_ready, tx_done, tx_abort, host_rts, ps2_clk_oe, ps2_dat_oe};
      if (snap_exp_q.size() > 0) begin
         se  = snap_exp_q.pop_front();
         sm  = snap_mask_q.pop_front();
         sid = snap_id_q.pop_front();
         n_cmp++;
         if ((act & sm) != (se & sm)) begin
            n_fail++;
            $display("FAIL %s: got {rdy,done,abort,rts,clk_oe,dat_oe}=%b want %b (mask %b) at cycle %0d",
                     snap_name(sid), act, se, sm, cyc);
         end
      end
      if (!reset_n) begin
         rx_cnt      = 0;
         start_cyc   = -1;
         prev_clk_oe = 1'b0;
         prev_dat_oe = 1'b0;
      end else begin
         if (tx_valid && tx_ready) acc_cyc = cyc;
         if (ps2_dat_oe && !prev_dat_oe && rx_cnt == 0) start_cyc = cyc;
         if (ps2_clk_oe && !prev_clk_oe) begin
            if (rx_cnt < 11) rx_frame[rx_cnt] = pad_dat;
            rx_cnt++;
         end
         if (tx_abort) begin
            n_cmp++;
            if (abort_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_abort: got tx_abort=1 want 0 at cycle %0d", cyc);
            end else begin
               void'(abort_q.pop_front());
               n_cmp++;
               if ({ps2_clk_oe, ps2_dat_oe} != 2'b00) begin
                  n_fail++;
                  $display("FAIL abort_release: got clk_oe,dat_oe=%b want 00", {ps2_clk_oe, ps2_dat_oe});
               end
            end
            rx_cnt    = 0;
            start_cyc = -1;
         end
         if (tx_done) begin
            n_cmp++;
            if (exp_frame_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_done: got tx_done=1 want 0 at cycle %0d", cyc);
            end else begin
               ef = exp_frame_q.pop_front();
               ea = exp_acc_q.pop_front();
               n_cmp++;
               if (rx_cnt != 11 || rx_frame != ef) begin
                  n_fail++;
                  $display("FAIL frame: got %03h (%0d clock pulses) want %03h (11 pulses)", rx_frame, rx_cnt, ef);
               end
               n_cmp++;
               if (cyc - start_cyc != FRAME_CYC) begin
                  n_fail++;
                  $display("FAIL start_to_done: got %0d cycles want %0d", cyc - start_cyc, FRAME_CYC);
               end
               if (ea) begin
                  n_cmp++;
                  if (start_cyc - acc_cyc != ACC_LAT) begin
                     n_fail++;
                     $display("FAIL accept_to_start: got %0d cycles want %0d", start_cyc - acc_cyc, ACC_LAT);
                  end
               end
            end
            rx_cnt    = 0;
            start_cyc = -1;
         end
         prev_clk_oe = ps2_clk_oe;
         prev_dat_oe = ps2_dat_oe;
      end
      if (end_req && !end_ack) begin
         n_cmp++;
         if (exp_frame_q.size() != 0) begin
            n_fail++;
            $display("FAIL frames_outstanding: got %0d want 0", exp_frame_q.size());
         end
         n_cmp++;
         if (abort_q.size() != 0) begin
            n_fail++;
            $display("FAIL aborts_outstanding: got %0d want 0", abort_q.size());
         end
         end_ack = 1'b1;
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic snap(input int id, input logic [5:0] e, input logic [5:0] m);
      snap_exp_q.push_back(e);
      snap_mask_q.push_back(m);
      snap_id_q.push_back(id);
   endtask

   task automatic send(input logic [7:0] b);
      bit was_ready;
      bit ok;
      ok       = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         was_ready = tx_ready;
         tick();
         if (was_ready) begin
            ok = 1'b1;
            break;
         end
      end
      tx_valid = 1'b0;
      if (!ok) snap(ID_TMO_ACC, 6'b100000, 6'b100000);
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (tx_done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) snap(ID_TMO_DONE, 6'b010000, 6'b010000);
   endtask

   task automatic wait_clk_falls(input int n);
      int   cnt;
      logic prev;
      cnt = 0;
      for (int i = 0; i < 4000 && cnt < n; i++) begin
         prev = ps2_clk_oe;
         tick();
         if (ps2_clk_oe && !prev) cnt++;
      end
      if (cnt < n) snap(ID_TMO_CLK, 6'b000010, 6'b000010);
   endtask

   task automatic wait_clk_rel();
      logic prev;
      for (int i = 0; i < 4000; i++) begin
         prev = ps2_clk_oe;
         tick();
         if (prev && !ps2_clk_oe) break;
      end
   endtask

   initial begin
      ticks(3);
      snap(ID_RST, 6'b100000, 6'b111111);
      tick();
      reset_n = 1'b1;
      ticks(30);
      snap(ID_IDLE, 6'b100000, 6'b111111);
      tick();

      // Normal byte 0x1C: start 0, 0,0,1,1,1,0,0,0, parity 0, stop 1.
      exp_frame_q.push_back(11'h438); exp_acc_q.push_back(1'b1);
      send(8'h1C);
      wait_done();
      snap(ID_DONE_CYC, 6'b010000, 6'b110000);
      tick();
      snap(ID_READY, 6'b100000, 6'b110000);
      ticks(5);

      // Back-to-back 0xFF (parity 1) then 0x00 (parity 1).
      exp_frame_q.push_back(11'h7FE); exp_acc_q.push_back(1'b1);
      send(8'hFF);
      exp_frame_q.push_back(11'h600); exp_acc_q.push_back(1'b1);
      send(8'h00);
      wait_done();
      ticks(5);

      // Host inhibit during bit 4, byte retried after release.
      exp_frame_q.push_back(11'h74A); exp_acc_q.push_back(1'b0);
      abort_q.push_back(4);
      send(8'hA5);
      wait_clk_falls(4);
      wait_clk_rel();
      ticks(5);
      host_clk_low = 1'b1;
      ticks(100);
      snap(ID_INH_HOLD, 6'b000000, 6'b011011);
      tick();
      host_clk_low = 1'b0;
      wait_done();
      ticks(5);

      // Inhibit during bit 10 is ignored.
      exp_frame_q.push_back(11'h678); exp_acc_q.push_back(1'b0);
      send(8'h3C);
      wait_clk_falls(10);
      wait_clk_rel();
      ticks(4);
      host_clk_low = 1'b1;
      wait_done();
      ticks(10);
      host_clk_low = 1'b0;
      ticks(40);

      // Request-to-send: data held low with clock high while a byte is pending.
      host_dat_low = 1'b1;
      ticks(5);
      exp_frame_q.push_back(11'h702); exp_acc_q.push_back(1'b0);
      send(8'h81);
      ticks(60);
      snap(ID_RTS, 6'b000100, 6'b111111);
      tick();
      host_dat_low = 1'b0;
      ticks(IDLE_CYC + 3);
      snap(ID_RTS_PRE, 6'b000000, 6'b011111);
      tick();
      snap(ID_RTS_START, 6'b000001, 6'b011111);
      wait_done();
      ticks(5);

      // Reset during bit 6 of 0x55 (clock and data both driven low at that point).
      send(8'h55);
      wait_clk_falls(6);
      ticks(18);
      snap(ID_PRE_RST, 6'b000011, 6'b000011);
      tick();
      reset_n = 1'b0;
      snap(ID_RST_MID, 6'b100000, 6'b111111);
      ticks(3);
      reset_n = 1'b1;
      tick();
      snap(ID_RST_REL, 6'b100000, 6'b111111);
      ticks(300);

      end_req = 1'b1;
      for (int i = 0; i < 20 && !end_ack; i++) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
